// File: rtl/fifo_read_drainer.sv
// Read-domain consumer of the async FIFO: pops words under a credit rule into a
// 2-entry skid buffer, streams them out on valid/ready, and counts/sequence-checks captures.
module fifo_read_drainer #(
    parameter int DATA_BITS = 10,
    parameter int CNT_BITS  = 16
) (
    input  logic                 r_clk,
    input  logic                 r_reset,
    input  logic                 empty,
    input  logic [DATA_BITS-1:0] output_data,
    output logic                 read,
    input  logic                 enable,
    input  logic                 seq_check_en,
    output logic [DATA_BITS-1:0] m_data,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic [CNT_BITS-1:0]  rd_count,
    output logic                 seq_err
);

    logic [1:0]           occ_q, occ_d;
    logic                 inflight_q, inflight_d;
    logic [DATA_BITS-1:0] head_q, head_d;
    logic [DATA_BITS-1:0] tail_q, tail_d;
    logic [CNT_BITS-1:0]  rd_count_q, rd_count_d;
    logic [DATA_BITS-1:0] expected_q, expected_d;
    logic                 seq_err_q, seq_err_d;

    logic                 pop;
    logic                 push;
    logic [2:0]           credit_used;
    logic [2:0]           credit_limit;

    function automatic logic [DATA_BITS-1:0] next_seq(input logic [DATA_BITS-1:0] value);
        return value + 1'b1;
    endfunction

    function automatic logic [CNT_BITS-1:0] next_count(input logic [CNT_BITS-1:0] value);
        return value + 1'b1;
    endfunction

    // Credit rule: buffered words plus the word in flight, less the one leaving now,
    // must stay below the buffer depth so a capture always finds a free slot.
    always_comb begin
        pop          = (occ_q != 2'd0) & m_ready;
        push         = inflight_q;
        credit_used  = {1'b0, occ_q} + {2'b00, inflight_q};
        credit_limit = 3'd2 + {2'b00, pop};
        read         = enable & ~empty & ~r_reset & (credit_used < credit_limit);
        inflight_d   = read;
    end

    always_comb begin
        occ_d  = occ_q;
        head_d = head_q;
        tail_d = tail_q;
        case ({push, pop})
            2'b10: begin
                occ_d = occ_q + 2'd1;
                if (occ_q == 2'd0) begin
                    head_d = output_data;
                end else begin
                    tail_d = output_data;
                end
            end
            2'b01: begin
                occ_d  = occ_q - 2'd1;
                head_d = tail_q;
            end
            2'b11: begin
                // Simultaneous push and pop keeps occupancy; order is preserved.
                if (occ_q == 2'd1) begin
                    head_d = output_data;
                end else begin
                    head_d = tail_q;
                    tail_d = output_data;
                end
            end
            default: begin
                occ_d = occ_q;
            end
        endcase
    end

    always_comb begin
        rd_count_d = rd_count_q;
        expected_d = expected_q;
        seq_err_d  = seq_err_q;
        if (push) begin
            rd_count_d = next_count(rd_count_q);
            expected_d = next_seq(output_data);
            if (seq_check_en && (output_data != expected_q)) begin
                seq_err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge r_clk or posedge r_reset) begin
        if (r_reset) begin
            occ_q      <= 2'd0;
            inflight_q <= 1'b0;
            head_q     <= '0;
            tail_q     <= '0;
            rd_count_q <= '0;
            expected_q <= '0;
            seq_err_q  <= 1'b0;
        end else begin
            occ_q      <= occ_d;
            inflight_q <= inflight_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            rd_count_q <= rd_count_d;
            expected_q <= expected_d;
            seq_err_q  <= seq_err_d;
        end
    end

    assign m_data   = head_q;
    assign m_valid  = (occ_q != 2'd0);
    assign rd_count = rd_count_q;
    assign seq_err  = seq_err_q;

endmodule
